// File: rtl/inst_prefetch_if.sv
// Bundle of the fetch-side and memory-side signals of the instruction prefetch buffer.
// The master modport is the buffer. The slave modport is the CPU/memory environment.
interface inst_prefetch_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic [LW-1:0] level;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc, level
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, level
  );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding memory read, a small PC+word FIFO,
// and a flush/restart path for branch redirects.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_prefetch_if.master   bus,
  output logic [1:0]        state_dbg
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [LW:0] DEPTH_W = (LW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

   // Handshakes: a memory word transfers on mem_req & mem_ack (mem_addr held while mem_req);
   // the head instruction transfers on inst_valid & inst_ready & ~redirect.
   state_t        state_q, state_n;
   logic [31:0]   fetch_pc_q, fetch_pc_n;
   logic [31:0]   req_addr_q, req_addr_n;
   logic [LW-1:0] level_q;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic          pop, push, ack;
   logic [LW:0]   cnt_p;
   logic [31:0]   target;

   assign pop    = (level_q != '0) & bus.inst_ready & ~bus.redirect;
   assign cnt_p  = {1'b0, level_q} - (LW + 1)'(pop);
   assign ack    = bus.mem_ack & (state_q != IDLE);
   assign target = bus.redirect_pc & ~32'h3;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_n;
         fetch_pc_q <= fetch_pc_n;
         req_addr_q <= req_addr_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      fetch_pc_n = fetch_pc_q;
      req_addr_n = req_addr_q;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.redirect) begin
               fetch_pc_n = target;
            end else if (cnt_p < DEPTH_W) begin
               state_n    = WAIT;
               req_addr_n = fetch_pc_q;
               fetch_pc_n = fetch_pc_q + 32'd4;
            end
         end
         WAIT: begin
            if (bus.redirect) begin
               // The request cannot be withdrawn; without its ack we must absorb it in DROP.
               fetch_pc_n = target;
               state_n    = ack ? IDLE : DROP;
            end else if (ack) begin
               push = 1'b1;
               if (cnt_p + (LW + 1)'(1) < DEPTH_W) begin
                  req_addr_n = fetch_pc_q;
                  fetch_pc_n = fetch_pc_q + 32'd4;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DROP: begin
            if (bus.redirect) fetch_pc_n = target;
            if (ack) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req    = (state_q != IDLE);
      bus.mem_addr   = req_addr_q;
      bus.inst_valid = (level_q != '0);
      bus.inst       = data_mem[rd_ptr_q];
      bus.inst_pc    = pc_mem[rd_ptr_q];
      bus.level      = level_q;
      state_dbg      = state_q;
   end

   // Redirect flushes in every state and overrides any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst || bus.redirect) begin
         level_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst && !bus.redirect) begin
         pc_mem[wr_ptr_q]   <= req_addr_q;
         data_mem[wr_ptr_q] <= bus.mem_rdata;
      end
   end
endmodule
